// File: rtl/std_cache_pkg.sv
// Shared types for the standard cache subsystem bypass path.
// Holds the per-port bypass request/response structs, the bypass arbiter
// state encoding and the arbiter's port-count ceiling.
package std_cache_pkg;

  localparam int BYPASS_MAX_PORTS = 16;
  // Wide enough to carry any arbiter port index up to BYPASS_MAX_PORTS.
  localparam int BYP_ID_W = 4;

  typedef enum logic [1:0] {
    BYP_IDLE,
    BYP_REQ,
    BYP_WAIT
  } bypass_state_e;

  typedef struct packed {
    logic                req;
    logic                we;
    logic [7:0]          be;
    logic [1:0]          size;
    logic [BYP_ID_W-1:0] id;
    logic [63:0]         addr;
    logic [63:0]         wdata;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set bit of req at or
// above ptr, wrapping from N-1 to 0. Zero latency; no backpressure.
// Ports: req (request vector), ptr (search start), vld (any request), idx (winner).
module rr_pick #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         vld,
  output logic [W-1:0] idx
);

  // Walk offsets from farthest to nearest so the last hit kept is the one
  // closest to ptr; avoids a loop break and keeps the logic flat.
  always_comb begin
    int j;
    vld = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        vld = 1'b1;
        idx = W'(j);
      end
    end
  end

endmodule

// File: rtl/std_bypass_arbiter.sv
// Round-robin arbiter of per-port uncached requests onto one bypass channel,
// one transaction outstanding; grant is same-cycle, response routed to origin.
// Backpressure: requesters hold req until gnt; REQ held until adapter gnt.
// Ports: clk_i, rst_i (async, active-high), req_i/rsp_o per port,
//        bypass_req_o/bypass_rsp_i to the adapter, busy_o (state != IDLE).
module std_bypass_arbiter
  import std_cache_pkg::*;
#(
  parameter int NR_PORTS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  bypass_req_t req_i [NR_PORTS-1:0],
  output bypass_rsp_t rsp_o [NR_PORTS-1:0],
  output bypass_req_t bypass_req_o,
  input  bypass_rsp_t bypass_rsp_i,
  output logic        busy_o
);

  localparam int PORT_W = $clog2(NR_PORTS);

  bypass_state_e     state_q, state_d;
  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0] sel_q, sel_d;
  bypass_req_t       lat_q, lat_d;

  logic [NR_PORTS-1:0] req_vec;
  logic                pick_vld;
  logic [PORT_W-1:0]   pick_idx;
  logic                done;
  // Adapter valid with nothing outstanding; dropped, only flagged.
  logic                stray_rsp;

  always_comb begin
    for (int i = 0; i < NR_PORTS; i++) req_vec[i] = req_i[i].req;
  end

  rr_pick #(.N(NR_PORTS)) u_pick (
    .req (req_vec),
    .ptr (rr_ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= BYP_IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      lat_q    <= lat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    sel_d        = sel_q;
    lat_d        = lat_q;
    done         = 1'b0;
    stray_rsp    = 1'b0;
    bypass_req_o = '0;
    for (int i = 0; i < NR_PORTS; i++) rsp_o[i] = '0;

    case (state_q)
      BYP_IDLE: begin
        stray_rsp = bypass_rsp_i.valid;
        // Grant is combinational, so it must also be suppressed while reset
        // is held or a requester could see a grant that is never serviced.
        if (pick_vld && !rst_i) begin
          rsp_o[pick_idx].gnt = 1'b1;
          lat_d               = req_i[pick_idx];
          lat_d.id            = BYP_ID_W'(pick_idx);
          sel_d               = pick_idx;
          state_d             = BYP_REQ;
        end
      end
      BYP_REQ: begin
        bypass_req_o     = lat_q;
        bypass_req_o.req = 1'b1;
        if (bypass_rsp_i.gnt) begin
          if (bypass_rsp_i.valid) begin
            done    = 1'b1;
            state_d = BYP_IDLE;
          end else begin
            state_d = BYP_WAIT;
          end
        end else begin
          stray_rsp = bypass_rsp_i.valid;
        end
      end
      BYP_WAIT: begin
        if (bypass_rsp_i.valid) begin
          done    = 1'b1;
          state_d = BYP_IDLE;
        end
      end
      default: state_d = BYP_IDLE;
    endcase

    // Pointer moves only on completion so a held request cannot be starved.
    if (done) begin
      rsp_o[sel_q].valid = 1'b1;
      rsp_o[sel_q].rdata = bypass_rsp_i.rdata;
      rr_ptr_d = (sel_q == PORT_W'(NR_PORTS - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  assign busy_o = (state_q != BYP_IDLE);

  a_no_stray_rsp : assert property (@(posedge clk_i) disable iff (rst_i) !stray_rsp)
    else $warning("bypass adapter valid with no outstanding granted request");

endmodule

// File: tb/tb_std_bypass_arbiter.sv
module tb_std_bypass_arbiter;
  import std_cache_pkg::*;

  localparam int NP = 4;

  logic        clk_i;
  logic        rst_i;
  bypass_req_t req_i [NP-1:0];
  bypass_rsp_t rsp_o [NP-1:0];
  bypass_req_t bypass_req_o;
  bypass_rsp_t bypass_rsp_i;
  logic        busy_o;

  int n_chk;
  int n_fail;

  std_bypass_arbiter #(.NR_PORTS(NP)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .rsp_o        (rsp_o),
    .bypass_req_o (bypass_req_o),
    .bypass_rsp_i (bypass_rsp_i),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bypass_req_t mk_req(input logic we, input logic [7:0] be,
                                         input logic [63:0] addr, input logic [1:0] size,
                                         input logic [63:0] wdata, input logic [3:0] id);
    bypass_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.we    = we;
    r.be    = be;
    r.addr  = addr;
    r.size  = size;
    r.wdata = wdata;
    r.id    = id;
    return r;
  endfunction

  // 15 = no grant, 14 = more than one grant.
  function automatic int gnt_idx();
    int w;
    int n;
    w = 15;
    n = 0;
    for (int i = 0; i < NP; i++) begin
      if (rsp_o[i].gnt) begin
        w = i;
        n++;
      end
    end
    if (n > 1) w = 14;
    return w;
  endfunction

  function automatic logic rsp_any();
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < NP; i++) acc = acc | (|rsp_o[i]);
    return acc;
  endfunction

  function automatic int valid_cnt();
    int n;
    n = 0;
    for (int i = 0; i < NP; i++) n += int'(rsp_o[i].valid);
    return n;
  endfunction

  int exp_order [6] = '{0, 1, 3, 0, 1, 3};
  int w;
  int p2_grants;

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    p2_grants    = 0;
    rst_i        = 1'b1;
    bypass_rsp_i = '0;
    for (int i = 0; i < NP; i++) req_i[i] = '0;

    // Reset state, including a request presented while reset is held.
    #12;
    check("rst_busy", busy_o, 0);
    check("rst_byp_req", |bypass_req_o, 0);
    check("rst_rsp", rsp_any(), 0);
    req_i[1] = mk_req(0, 8'hFF, 64'h40, 2'd3, 64'h0, 4'h0);
    #1;
    check("rst_no_gnt", rsp_any(), 0);
    req_i[1] = '0;
    tick();
    rst_i = 1'b0;

    // 1. Single read from port 2 (requester id field deliberately wrong).
    tick();
    req_i[2] = mk_req(0, 8'hFF, 64'h8000_0040, 2'd3, 64'h0, 4'h7);
    #1;
    check("t1_gnt", gnt_idx(), 2);
    check("t1_idle_busy", busy_o, 0);
    tick();
    req_i[2] = '0;
    #1;
    check("t1_busy", busy_o, 1);
    check("t1_req", bypass_req_o.req, 1);
    check("t1_id", bypass_req_o.id, 2);
    check("t1_addr", bypass_req_o.addr, 64'h8000_0040);
    check("t1_size", bypass_req_o.size, 3);
    tick();
    check("t1_hold", bypass_req_o.req, 1);
    tick();
    bypass_rsp_i.gnt = 1'b1;
    #1;
    check("t1_hold_gnt", bypass_req_o.req, 1);
    tick();
    bypass_rsp_i.gnt = 1'b0;
    #1;
    check("t1_req_drop", bypass_req_o.req, 0);
    check("t1_wait_busy", busy_o, 1);
    tick();
    tick();
    bypass_rsp_i.valid = 1'b1;
    bypass_rsp_i.rdata = 64'hDEAD_BEEF_0000_1234;
    #1;
    check("t1_valid", rsp_o[2].valid, 1);
    check("t1_rdata", rsp_o[2].rdata, 64'hDEAD_BEEF_0000_1234);
    check("t1_other_rdata", rsp_o[1].rdata, 0);
    check("t1_valid_cnt", valid_cnt(), 1);
    tick();
    bypass_rsp_i = '0;
    #1;
    check("t1_done_busy", busy_o, 0);

    // 2/3. Fairness with gnt+valid coinciding; reset first so rr_ptr = 0.
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    req_i[0] = mk_req(0, 8'hFF, 64'h100, 2'd3, 64'h0, 4'h0);
    req_i[1] = mk_req(0, 8'hFF, 64'h200, 2'd3, 64'h0, 4'h0);
    req_i[3] = mk_req(0, 8'hFF, 64'h300, 2'd3, 64'h0, 4'h0);
    #1;
    for (int t = 0; t < 6; t++) begin
      w = gnt_idx();
      if (rsp_o[2].gnt) p2_grants++;
      check("t2_order", w, exp_order[t]);
      check("t3_idle_busy", busy_o, 0);
      tick();
      bypass_rsp_i.gnt   = 1'b1;
      bypass_rsp_i.valid = 1'b1;
      bypass_rsp_i.rdata = 64'h100 + t;
      #1;
      check("t2_id", bypass_req_o.id, exp_order[t]);
      check("t3_valid", rsp_o[exp_order[t]].valid, 1);
      check("t3_rdata", rsp_o[exp_order[t]].rdata, 64'h100 + t);
      check("t3_valid_cnt", valid_cnt(), 1);
      tick();
      bypass_rsp_i = '0;
      #1;
    end
    for (int i = 0; i < NP; i++) req_i[i] = '0;
    check("t2_port2_never", p2_grants, 0);

    // 4. Write from port 0 (rr_ptr back at 0).
    req_i[0] = mk_req(1, 8'h0F, 64'h1000, 2'd3, 64'h1122_3344_5566_7788, 4'h9);
    #1;
    check("t4_gnt", gnt_idx(), 0);
    tick();
    req_i[0] = '0;
    #1;
    check("t4_we", bypass_req_o.we, 1);
    check("t4_be", bypass_req_o.be, 8'h0F);
    check("t4_wdata", bypass_req_o.wdata, 64'h1122_3344_5566_7788);
    check("t4_id", bypass_req_o.id, 0);
    tick();
    bypass_rsp_i.gnt = 1'b1;
    tick();
    bypass_rsp_i.gnt   = 1'b0;
    bypass_rsp_i.valid = 1'b1;
    #1;
    check("t4_valid0", rsp_o[0].valid, 1);
    check("t4_valid_cnt", valid_cnt(), 1);
    tick();
    bypass_rsp_i = '0;
    #1;
    check("t4_busy", busy_o, 0);

    // 5. Stray response in IDLE.
    bypass_rsp_i.valid = 1'b1;
    bypass_rsp_i.rdata = 64'hFFFF;
    #1;
    check("t5_no_rsp", rsp_any(), 0);
    check("t5_flag", dut.stray_rsp, 1);
    tick();
    bypass_rsp_i = '0;
    #1;
    check("t5_idle", busy_o, 0);

    // 6. Reset in WAIT_RSP; rr_ptr is 1 so port 3 wins over port 0 first.
    req_i[3] = mk_req(0, 8'hFF, 64'h3000, 2'd3, 64'h0, 4'h0);
    req_i[0] = mk_req(0, 8'hFF, 64'h0040, 2'd3, 64'h0, 4'h0);
    #1;
    check("t6_gnt3", gnt_idx(), 3);
    tick();
    req_i[3] = '0;
    req_i[0] = '0;
    tick();
    bypass_rsp_i.gnt = 1'b1;
    tick();
    bypass_rsp_i.gnt = 1'b0;
    #1;
    check("t6_wait_busy", busy_o, 1);
    req_i[3] = mk_req(0, 8'hFF, 64'h3000, 2'd3, 64'h0, 4'h0);
    req_i[0] = mk_req(0, 8'hFF, 64'h0040, 2'd3, 64'h0, 4'h0);
    #1;
    rst_i = 1'b1;
    #1;
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_byp", |bypass_req_o, 0);
    check("t6_rst_rsp", rsp_any(), 0);
    tick();
    rst_i = 1'b0;
    #1;
    check("t6_first_win", gnt_idx(), 0);
    for (int i = 0; i < NP; i++) req_i[i] = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
